// File: rtl/tie_opq_arb_pkg.sv
// Shared types and helpers for the TIE output-queue arbiter.
// TIMEOUT_MAX is only consumed when TIE_OPQ_ARB_TIMEOUT_EN is defined.
package tie_opq_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] TIMEOUT_MAX = 8'hFF;

  // Cyclic wrap for an index already known to be below 2*n.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/tie_rr_pick.sv
// Combinational round-robin picker: first requester at or after start, cyclic.
module tie_rr_pick
  import tie_opq_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  oh_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    oh_o  = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'(rr_wrap(32'(start_i) + k, N));
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    oh_o[idx_o] = vld_o;
  end

endmodule

// File: rtl/tie_opq_arbiter.sv
// Round-robin arbiter with message lock feeding the TIE output queue through a
// one-entry holding register. Optional lock-idle timeout: TIE_OPQ_ARB_TIMEOUT_EN.
module tie_opq_arbiter
  import tie_opq_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     TIE_OPQ_PushReq,
  output logic [DW-1:0]            TIE_OPQ,
  input  logic                     TIE_OPQ_Full,
  output logic [$clog2(NREQ)-1:0]  owner
`ifdef TIE_OPQ_ARB_TIMEOUT_EN
  ,
  output logic                     lock_timeout
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          push_q, push_d;
  logic [DW-1:0] hold_q, hold_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  logic          accept;
  logic          slot_free;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;

`ifdef TIE_OPQ_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
`endif

  tie_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .start_i (rr_q),
    .oh_o    (pick_oh),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  always_comb begin
    accept    = push_q && !TIE_OPQ_Full;
    slot_free = !push_q || accept;

    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    if (state_q == IDLE) begin
      gnt_vld = pick_vld;
      gnt_idx = pick_idx;
    end else begin
      gnt_vld = req[owner_q];
    end
    // Grant is suppressed during reset so the port reads idle while RESET_N is low.
    gnt_vld = gnt_vld && slot_free && RESET_N;

    gnt     = '0;
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    push_d  = push_q;
    hold_d  = hold_q;

    if (accept)
      push_d = 1'b0;

    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
      push_d       = 1'b1;
      hold_d       = req_data[gnt_idx*DW +: DW];
      owner_d      = gnt_idx;
      rr_d         = IW'(rr_wrap(32'(gnt_idx) + 1, NREQ));
      state_d      = req_lock[gnt_idx] ? LOCKED : IDLE;
    end

`ifdef TIE_OPQ_ARB_TIMEOUT_EN
    cnt_d = '0;
    tmo_d = 1'b0;
    if (state_q == LOCKED && !gnt_vld) begin
      if (cnt_q == TIMEOUT_MAX) begin
        state_d = IDLE;
        tmo_d   = 1'b1;
      end else if (!req[owner_q]) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      push_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      push_q  <= push_d;
      hold_q  <= hold_d;
    end
  end

`ifdef TIE_OPQ_ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign lock_timeout = tmo_q;
`endif

  assign TIE_OPQ_PushReq = push_q;
  assign TIE_OPQ         = hold_q;
  assign owner           = owner_q;

endmodule

// File: tb/tb_tie_opq_arbiter.sv
// Directed bench for tie_opq_arbiter (NREQ=4, DW=32), expectations hand-derived.
module tb_tie_opq_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_lock;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                TIE_OPQ_PushReq;
  logic [DW-1:0]       TIE_OPQ;
  logic                TIE_OPQ_Full;
  logic [1:0]          owner;
`ifdef TIE_OPQ_ARB_TIMEOUT_EN
  logic                lock_timeout;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] D2 = 32'h3333_3333;
  localparam logic [31:0] D3 = 32'h4444_4444;

  tie_opq_arbiter #(
    .NREQ (NREQ),
    .DW   (DW)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .req             (req),
    .req_lock        (req_lock),
    .req_data        (req_data),
    .gnt             (gnt),
    .TIE_OPQ_PushReq (TIE_OPQ_PushReq),
    .TIE_OPQ         (TIE_OPQ),
    .TIE_OPQ_Full    (TIE_OPQ_Full),
    .owner           (owner)
`ifdef TIE_OPQ_ARB_TIMEOUT_EN
    ,
    .lock_timeout    (lock_timeout)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] dw [4];
    int unsigned idle_bad;
    dw[0] = D0; dw[1] = D1; dw[2] = D2; dw[3] = D3;

    RESET_N = 1'b0; req = '0; req_lock = '0; TIE_OPQ_Full = 1'b0;
    req_data = {D3, D2, D1, D0};
    step(); step();
    look();
    chk("rst_gnt",  64'(gnt), 64'h0);
    chk("rst_push", 64'(TIE_OPQ_PushReq), 64'h0);
    chk("rst_data", 64'(TIE_OPQ), 64'h0);
    chk("rst_own",  64'(owner), 64'h0);
    step();

    // 1: all four requesting, no lock
    RESET_N = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      look();
      chk($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rr_push%0d", k), 64'(TIE_OPQ_PushReq), (k > 0) ? 64'h1 : 64'h0);
      if (k > 0) chk($sformatf("rr_data%0d", k), 64'(TIE_OPQ), 64'(dw[k-1]));
      step();
    end

    // 2: Full back-pressure on a pending word
    req = '0;
    look();
    chk("drain_data", 64'(TIE_OPQ), 64'(D0));
    step();
    req_data[1*DW +: DW] = 32'hA5A5_A5A5; req = 4'b0010;
    look();
    chk("full_pre_gnt", 64'(gnt), 64'h2);
    step();
    req = 4'b0100; TIE_OPQ_Full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      look();
      chk($sformatf("full_gnt%0d", k),  64'(gnt), 64'h0);
      chk($sformatf("full_data%0d", k), 64'(TIE_OPQ), 64'hA5A5_A5A5);
      chk($sformatf("full_push%0d", k), 64'(TIE_OPQ_PushReq), 64'h1);
      step();
    end
    TIE_OPQ_Full = 1'b0;
    look();
    chk("unfull_gnt", 64'(gnt), 64'h4);
    chk("unfull_data", 64'(TIE_OPQ), 64'hA5A5_A5A5);
    step();
    req = '0;
    look();
    chk("unfull_next", 64'(TIE_OPQ), 64'(D2));
    chk("unfull_own", 64'(owner), 64'h2);
    step();

    // 4: rr wrap from owner 3
    req = 4'b1000;
    look();
    chk("wrap_g3", 64'(gnt), 64'h8);
    step();
    req = 4'b1001;
    look();
    chk("wrap_own3", 64'(owner), 64'h3);
    chk("wrap_g0", 64'(gnt), 64'h1);
    step();
    look();
    chk("wrap_g3b", 64'(gnt), 64'h8);
    step();

    // 3: locked message from producer 2 while producer 0 waits
    req = 4'b0010;
    look();
    chk("lk_pre", 64'(gnt), 64'h2);
    step();
    req = 4'b0101; req_lock = 4'b0100;
    look();
    chk("lk_w0", 64'(gnt), 64'h4);
    step();
    req = 4'b0001;
    look();
    chk("lk_stall", 64'(gnt), 64'h0);
    chk("lk_own", 64'(owner), 64'h2);
    step();
    req = 4'b0101;
    for (int k = 1; k < 3; k++) begin
      look();
      chk($sformatf("lk_w%0d", k), 64'(gnt), 64'h4);
      step();
    end
    req_lock = '0;
    look();
    chk("lk_last", 64'(gnt), 64'h4);
    step();
    look();
    chk("lk_after", 64'(gnt), 64'h1);
    chk("lk_data", 64'(TIE_OPQ), 64'(D2));
    step();

    // 5: reset while locked with a word in flight
    req = 4'b0010; req_lock = 4'b0010;
    look();
    chk("rl_gnt", 64'(gnt), 64'h2);
    step();
    RESET_N = 1'b0;
    look();
    chk("rl_push_pre", 64'(TIE_OPQ_PushReq), 64'h1);
    step();
    look();
    chk("rl_push", 64'(TIE_OPQ_PushReq), 64'h0);
    chk("rl_gnt0", 64'(gnt), 64'h0);
    chk("rl_own", 64'(owner), 64'h0);
    chk("rl_data", 64'(TIE_OPQ), 64'h0);
    step();
    RESET_N = 1'b1; req = 4'b1010; req_lock = '0;
    look();
    chk("rl_idle", 64'(gnt), 64'h2);
    step();

    // 6: owner goes idle inside a locked message
    req = 4'b0001; req_lock = 4'b0001;
    look();
    chk("to_lock", 64'(gnt), 64'h1);
    step();
    req = 4'b0010; req_lock = '0;
    idle_bad = 0;
`ifdef TIE_OPQ_ARB_TIMEOUT_EN
    for (int j = 0; j < 256; j++) begin
      look();
      if (gnt !== '0 || lock_timeout !== 1'b0) idle_bad++;
      step();
    end
    chk("to_wait", 64'(idle_bad), 64'h0);
    look();
    chk("to_pulse", 64'(lock_timeout), 64'h1);
    chk("to_other", 64'(gnt), 64'h2);
    step();
    look();
    chk("to_pulse_end", 64'(lock_timeout), 64'h0);
    step();
`else
    for (int j = 0; j < 20; j++) begin
      look();
      if (gnt !== '0) idle_bad++;
      step();
    end
    chk("lk_hold", 64'(idle_bad), 64'h0);
    req = 4'b0011;
    look();
    chk("lk_unlock", 64'(gnt), 64'h1);
    step();
    look();
    chk("lk_other", 64'(gnt), 64'h2);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
